// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: sequences whack-a-mole rounds (gap, show, level-up,
// miss-out, game over) and drives target load and display blanking.
module mole_round_scheduler #(
    parameter int unsigned CW             = 24,
    parameter int unsigned DWELL_INIT     = 10_000_000,
    parameter int unsigned DWELL_STEP     = 1_000_000,
    parameter int unsigned DWELL_MIN      = 2_000_000,
    parameter int unsigned GAP_CYCLES     = 1_000_000,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_MISSES     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    rand_seg,
    input  logic          hit,
    input  logic          timer_end,
    output logic          mole_active,
    output logic          mole_req,
    output logic [2:0]    segment_select,
    output logic [3:0]    level,
    output logic [CW-1:0] dwell_cycles,
    output logic [3:0]    miss_cnt,
    output logic          round_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int unsigned HW = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [CW-1:0] DWELL_INIT_C = CW'(DWELL_INIT);
    localparam logic [CW-1:0] DWELL_STEP_C = CW'(DWELL_STEP);
    localparam logic [CW-1:0] DWELL_MIN_C  = CW'(DWELL_MIN);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMER_ONE    = CW'(1);
    // One extra bit so MIN+STEP cannot wrap when compared against dwell.
    localparam logic [CW:0]   DWELL_KNEE   = (CW + 1)'(DWELL_MIN + DWELL_STEP);
    localparam logic [HW-1:0] HPL_C        = HW'(HITS_PER_LEVEL);
    localparam logic [HW-1:0] HIT_ONE      = HW'(1);
    localparam logic [3:0]    MAX_MISS_C   = 4'(MAX_MISSES);

    state_t        state_q,       state_d;
    logic [CW-1:0] timer_q,       timer_d;
    logic [HW-1:0] hit_ctr_q,     hit_ctr_d;
    logic [2:0]    prev_q,        prev_d;
    logic          mole_active_q, mole_active_d;
    logic          mole_req_q,    mole_req_d;
    logic [2:0]    seg_q,         seg_d;
    logic [3:0]    level_q,       level_d;
    logic [CW-1:0] dwell_q,       dwell_d;
    logic [3:0]    miss_q,        miss_d;
    logic          over_q,        over_d;

    logic [2:0]    cand;
    logic [2:0]    pick;
    logic [3:0]    miss_inc;
    logic          do_init;

    // Target pick: fold 7 onto 0, then step past a repeat of the last target.
    always_comb begin
        cand = (rand_seg == 3'd7) ? 3'd0 : rand_seg;
        pick = cand;
        if (cand == prev_q) begin
            pick = (cand == 3'd6) ? 3'd0 : cand + 3'd1;
        end
    end

    // Next-state and registered-output values for the round FSM.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        hit_ctr_d     = hit_ctr_q;
        prev_d        = prev_q;
        mole_active_d = mole_active_q;
        mole_req_d    = 1'b0;
        seg_d         = seg_q;
        level_d       = level_q;
        dwell_d       = dwell_q;
        miss_d        = miss_q;
        over_d        = over_q;
        miss_inc      = miss_q + 4'd1;
        do_init       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    do_init = 1'b1;
                end
            end
            GAP: begin
                mole_active_d = 1'b0;
                if (timer_end) begin
                    state_d = OVER;
                    over_d  = 1'b1;
                end else if (timer_q == '0) begin
                    state_d       = SHOW;
                    mole_active_d = 1'b1;
                    mole_req_d    = 1'b1;
                    timer_d       = dwell_q - TIMER_ONE;
                    seg_d         = pick;
                    prev_d        = pick;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            SHOW: begin
                if (timer_end) begin
                    state_d       = OVER;
                    over_d        = 1'b1;
                    mole_active_d = 1'b0;
                end else if (hit) begin
                    state_d       = GAP;
                    timer_d       = GAP_LAST;
                    mole_active_d = 1'b0;
                    if (hit_ctr_q + HIT_ONE == HPL_C) begin
                        hit_ctr_d = '0;
                        level_d   = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                        dwell_d   = ({1'b0, dwell_q} < DWELL_KNEE) ? DWELL_MIN_C
                                                                   : dwell_q - DWELL_STEP_C;
                    end else begin
                        hit_ctr_d = hit_ctr_q + HIT_ONE;
                    end
                end else if (timer_q == '0) begin
                    miss_d        = miss_inc;
                    mole_active_d = 1'b0;
                    if (miss_inc == MAX_MISS_C) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        timer_d = GAP_LAST;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            OVER: begin
                mole_active_d = 1'b0;
                if (start) begin
                    do_init = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Game (re)start from IDLE or OVER.
        if (do_init) begin
            state_d       = GAP;
            level_d       = '0;
            dwell_d       = DWELL_INIT_C;
            miss_d        = '0;
            hit_ctr_d     = '0;
            timer_d       = GAP_LAST;
            mole_active_d = 1'b0;
            over_d        = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            hit_ctr_q     <= '0;
            prev_q        <= '0;
            mole_active_q <= 1'b0;
            mole_req_q    <= 1'b0;
            seg_q         <= '0;
            level_q       <= '0;
            dwell_q       <= DWELL_INIT_C;
            miss_q        <= '0;
            over_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            hit_ctr_q     <= hit_ctr_d;
            prev_q        <= prev_d;
            mole_active_q <= mole_active_d;
            mole_req_q    <= mole_req_d;
            seg_q         <= seg_d;
            level_q       <= level_d;
            dwell_q       <= dwell_d;
            miss_q        <= miss_d;
            over_q        <= over_d;
        end
    end

    assign mole_active    = mole_active_q;
    assign mole_req       = mole_req_q;
    assign segment_select = seg_q;
    assign level          = level_q;
    assign dwell_cycles   = dwell_q;
    assign miss_cnt       = miss_q;
    assign round_over     = over_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb_mole_round_scheduler: directed table vectors plus hand-written
// multi-cycle sequences for mole_round_scheduler.
module tb_mole_round_scheduler;

    localparam int CW = 24;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    rand_seg;
    logic          hit;
    logic          timer_end;
    logic          mole_active;
    logic          mole_req;
    logic [2:0]    segment_select;
    logic [3:0]    level;
    logic [CW-1:0] dwell_cycles;
    logic [3:0]    miss_cnt;
    logic          round_over;

    int checks = 0;
    int errors = 0;

    mole_round_scheduler #(
        .CW(CW),
        .DWELL_INIT(20),
        .DWELL_STEP(4),
        .DWELL_MIN(8),
        .GAP_CYCLES(3),
        .HITS_PER_LEVEL(2),
        .MAX_MISSES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rand_seg(rand_seg),
        .hit(hit),
        .timer_end(timer_end),
        .mole_active(mole_active),
        .mole_req(mole_req),
        .segment_select(segment_select),
        .level(level),
        .dwell_cycles(dwell_cycles),
        .miss_cnt(miss_cnt),
        .round_over(round_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [2:0]    rs;
        logic          hit;
        logic          ma;
        logic          req;
        logic [2:0]    seg;
        logic [3:0]    lvl;
        logic [3:0]    miss;
        logic          ovr;
        logic [CW-1:0] dw;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic s, logic [2:0] rs, logic h, logic ma, logic rq,
                                logic [2:0] sg, logic [3:0] lv, logic [CW-1:0] dw);
        vec_t v;
        v.start = s;  v.rs = rs;  v.hit = h;
        v.ma = ma;    v.req = rq; v.seg = sg; v.lvl = lv;
        v.miss = 4'd0; v.ovr = 1'b0; v.dw = dw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Called just after the edge that leaves IDLE/OVER/SHOW; counts blank samples.
    task automatic wait_show(output int lows);
        int n;
        lows = 0;
        n = 0;
        while (mole_active !== 1'b1 && n < 60) begin
            lows++;
            step();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_show timeout actual=%0d required=<60", n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ma"},    32'(mole_active), 0);
        chk({tag, "_req"},   32'(mole_req), 0);
        chk({tag, "_seg"},   32'(segment_select), 0);
        chk({tag, "_lvl"},   32'(level), 0);
        chk({tag, "_dwell"}, 32'(dwell_cycles), 20);
        chk({tag, "_miss"},  32'(miss_cnt), 0);
        chk({tag, "_over"},  32'(round_over), 0);
    endtask

    initial begin
        int lows;
        int hi;
        int n;
        int lvl_m;
        int dwell_m;
        logic flag;

        rst = 1'b1; start = 1'b0; rand_seg = 3'd0; hit = 1'b0; timer_end = 1'b0;

        // Reset values while rst is held
        #12;
        chk_reset_vals("rst");
        rst = 1'b0;

        // Start latency, mole_req pulse, target selection
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 20);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 20);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 20);
        vecs[3]  = mk(0, 2, 0, 1, 1, 2, 0, 20);
        vecs[4]  = mk(0, 0, 0, 1, 0, 2, 0, 20);
        vecs[5]  = mk(0, 0, 1, 0, 0, 2, 0, 20);
        vecs[6]  = mk(0, 0, 0, 0, 0, 2, 0, 20);
        vecs[7]  = mk(0, 0, 0, 0, 0, 2, 0, 20);
        vecs[8]  = mk(0, 3, 0, 1, 1, 3, 0, 20);
        vecs[9]  = mk(0, 0, 1, 0, 0, 3, 1, 16);
        vecs[10] = mk(0, 0, 0, 0, 0, 3, 1, 16);
        vecs[11] = mk(0, 0, 0, 0, 0, 3, 1, 16);
        vecs[12] = mk(0, 7, 0, 1, 1, 0, 1, 16);
        vecs[13] = mk(0, 0, 1, 0, 0, 0, 1, 16);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 16);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 16);
        vecs[16] = mk(0, 6, 0, 1, 1, 6, 1, 16);
        vecs[17] = mk(0, 0, 1, 0, 0, 6, 2, 12);
        vecs[18] = mk(0, 0, 0, 0, 0, 6, 2, 12);
        vecs[19] = mk(0, 0, 0, 0, 0, 6, 2, 12);
        vecs[20] = mk(0, 6, 0, 1, 1, 0, 2, 12);

        for (int i = 0; i < 21; i++) begin
            start    = vecs[i].start;
            rand_seg = vecs[i].rs;
            hit      = vecs[i].hit;
            step();
            chk($sformatf("vec%0d_ma", i),    32'(mole_active),    32'(vecs[i].ma));
            chk($sformatf("vec%0d_req", i),   32'(mole_req),       32'(vecs[i].req));
            chk($sformatf("vec%0d_seg", i),   32'(segment_select), 32'(vecs[i].seg));
            chk($sformatf("vec%0d_lvl", i),   32'(level),          32'(vecs[i].lvl));
            chk($sformatf("vec%0d_miss", i),  32'(miss_cnt),       32'(vecs[i].miss));
            chk($sformatf("vec%0d_over", i),  32'(round_over),     32'(vecs[i].ovr));
            chk($sformatf("vec%0d_dwell", i), 32'(dwell_cycles),   32'(vecs[i].dw));
        end
        start = 1'b0; rand_seg = 3'd0; hit = 1'b0;

        // Leveling over 8 hit moles, dwell shrinking to the floor
        sync_reset();
        start = 1'b1; step(); start = 1'b0;
        lvl_m = 0;
        dwell_m = 20;
        for (int m = 0; m < 8; m++) begin
            wait_show(lows);
            chk($sformatf("lvl%0d_gap", m), 32'(lows), 3);
            chk($sformatf("lvl%0d_req", m), 32'(mole_req), 1);
            step();
            hit = 1'b1; step(); hit = 1'b0;
            if ((m + 1) % 2 == 0) begin
                lvl_m++;
                dwell_m = (dwell_m < 12) ? 8 : dwell_m - 4;
            end
            chk($sformatf("lvl%0d_level", m), 32'(level), 32'(lvl_m));
            chk($sformatf("lvl%0d_dwell", m), 32'(dwell_cycles), 32'(dwell_m));
            chk($sformatf("lvl%0d_ma", m), 32'(mole_active), 0);
        end

        // Async reset between edges while mole_req is high
        wait_show(lows);
        chk("async_pre_req", 32'(mole_req), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async");
        rst = 1'b0;
        flag = 1'b0;
        timer_end = 1'b1;
        hit = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mole_active || mole_req || round_over) flag = 1'b1;
        end
        timer_end = 1'b0; hit = 1'b0;
        chk("async_idle_hold", 32'(flag), 0);
        start = 1'b1; step(); start = 1'b0;
        wait_show(lows);
        chk("async_restart_gap", 32'(lows), 3);

        // Priority: hit on the final SHOW cycle counts as a hit
        sync_reset();
        start = 1'b1; step(); start = 1'b0;
        wait_show(lows);
        for (int c = 0; c < 19; c++) step();
        chk("pri_last_ma", 32'(mole_active), 1);
        hit = 1'b1; step(); hit = 1'b0;
        chk("pri_last_leave", 32'(mole_active), 0);
        chk("pri_last_miss", 32'(miss_cnt), 0);
        chk("pri_last_over", 32'(round_over), 0);
        wait_show(lows);
        hit = 1'b1; step(); hit = 1'b0;
        chk("pri_last_lvl", 32'(level), 1);
        chk("pri_last_dwell", 32'(dwell_cycles), 16);

        // Priority: hit together with timer_end -> OVER, no level-up
        wait_show(lows);
        hit = 1'b1; step(); hit = 1'b0;
        wait_show(lows);
        hit = 1'b1; timer_end = 1'b1; step(); hit = 1'b0; timer_end = 1'b0;
        chk("pri_te_over", 32'(round_over), 1);
        chk("pri_te_ma", 32'(mole_active), 0);
        chk("pri_te_lvl", 32'(level), 1);
        chk("pri_te_dwell", 32'(dwell_cycles), 16);

        // start from OVER with timer_end still high, then timer_end in GAP
        timer_end = 1'b1; start = 1'b1; step(); start = 1'b0;
        chk("over_start_over", 32'(round_over), 0);
        chk("over_start_lvl", 32'(level), 0);
        chk("over_start_dwell", 32'(dwell_cycles), 20);
        step();
        chk("gap_te_over", 32'(round_over), 1);
        timer_end = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (mole_req || mole_active) flag = 1'b1;
        end
        chk("gap_te_noreq", 32'(flag), 0);
        chk("gap_te_hold", 32'(round_over), 1);

        // Miss-out: three full-length timeouts end the game
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wait_show(lows);
            hi = 0;
            n = 0;
            while (mole_active === 1'b1 && n < 60) begin
                hi++;
                step();
                n++;
            end
            chk($sformatf("miss%0d_visible", i), 32'(hi), 20);
            chk($sformatf("miss%0d_cnt", i), 32'(miss_cnt), 32'(i));
            chk($sformatf("miss%0d_over", i), 32'(round_over), (i == 3) ? 1 : 0);
        end
        chk("missout_ma", 32'(mole_active), 0);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_over", 32'(round_over), 0);
        chk("restart_miss", 32'(miss_cnt), 0);
        chk("restart_lvl", 32'(level), 0);
        chk("restart_dwell", 32'(dwell_cycles), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
Sequences whack-a-mole rounds on top of the existing target-select, lockout and score datapath. It decides when each mole appears, which segment it lights, and how long it stays lit. It shortens the dwell window as the player levels up and ends the game after too many timed-out moles or when the global game timer expires. Its outputs drive the FSM target load and the display blanking.

Parameters:
CW, 24, width of dwell/gap counters
DWELL_INIT, 10_000_000, initial mole visible time in cycles (≥1)
DWELL_STEP, 1_000_000, dwell reduction per level-up
DWELL_MIN, 2_000_000, dwell floor (≤ DWELL_INIT)
GAP_CYCLES, 1_000_000, blank time between moles (≥1)
HITS_PER_LEVEL, 4, correct hits per level-up (≥1)
MAX_MISSES, 3, timed-out moles that end the game (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous, active-high
start  in  1  debounced start, one-cycle pulse
rand_seg  in  3  LFSR segment candidate
hit  in  1  one-cycle pulse, correct button on current target
timer_end  in  1  level from game timer, game time expired
mole_active  out  1  mole currently shown
mole_req  out  1  one-cycle pulse on first SHOW cycle; load new target
segment_select  out  3  current target, 0..6
level  out  4  current level, saturates at 15
dwell_cycles  out  CW  current dwell window
miss_cnt  out  4  timed-out moles this game
round_over  out  1  game finished, high in OVER

Behaviour:
- All outputs are registered. Async reset forces state IDLE and the following values: mole_active=0, mole_req=0, segment_select=0, level=0, dwell_cycles=DWELL_INIT, miss_cnt=0, round_over=0, internal timer=0, hit counter=0, prev target=0. Reset mid-game takes effect immediately; no pending pulse survives it.
- States: IDLE, GAP, SHOW, OVER.
- IDLE → GAP on start. Init on that edge: level=0, dwell=DWELL_INIT, miss_cnt=0, hit_ctr=0, timer=GAP_CYCLES-1. The same init applies on start from OVER.
- GAP:
  - mole_active=0.
  - If timer≠0, decrement.
  - If timer==0, go to SHOW. On that edge: mole_active=1, mole_req=1 for one cycle, timer=dwell-1, and the target is latched.
  - Target selection: cand = (rand_seg==7) ? 0 : rand_seg. If cand == prev target, use (cand+1) mod 7. Store the result as prev target.
  - Mole appears exactly GAP_CYCLES clocks after the edge that leaves IDLE/OVER or SHOW.
- SHOW: mole visible exactly dwell cycles unless hit. Per-cycle priority, highest first:
  1. timer_end → OVER; no level/miss update.
  2. hit:
     - hit_ctr+1. If it reaches HITS_PER_LEVEL: hit_ctr=0, level+1 (saturate 15), dwell = (dwell < DWELL_MIN+DWELL_STEP) ? DWELL_MIN : dwell-DWELL_STEP.
     - Go to GAP, timer=GAP_CYCLES-1.
  3. timer==0 (timeout):
     - miss_cnt+1.
     - If the new value == MAX_MISSES → OVER, else → GAP with timer=GAP_CYCLES-1.
  4. Otherwise decrement timer.
  - Leaving SHOW clears mole_active on the same edge.
- timer_end in GAP → OVER. timer_end in IDLE is ignored.
- OVER:
  - round_over=1, mole_active=0.
  - level, miss_cnt and segment_select hold.
  - start → GAP with init; round_over clears on that edge.
  - If timer_end is still high while start is pulsed, still go to GAP; timer_end is only checked in GAP/SHOW from the next cycle.
- start in GAP/SHOW is ignored. hit outside SHOW is ignored.
- dwell arithmetic is unsigned CW bits and never drops below DWELL_MIN. Level saturates. miss_cnt never exceeds MAX_MISSES.

Test Plan:
Bench parameters for all scenarios: DWELL_INIT=20, STEP=4, MIN=8, GAP=3, HITS_PER_LEVEL=2, MAX_MISSES=3.
1. Reset/start: rst high → all outputs at reset values, dwell_cycles=20. start pulse at edge k → mole_active and mole_req rise at edge k+3. mole_req is low at k+4.
2. Leveling: hit on each 2nd SHOW cycle for 8 moles → level 1/2/3/4 after hits 2/4/6/8; dwell_cycles 16/12/8/8; mole_active low for exactly 3 cycles between moles.
3. Miss-out: no hits → each mole visible exactly 20 cycles; miss_cnt 1, 2, then round_over=1 with miss_cnt=3 and mole_active=0. start → round_over=0, miss_cnt=0, level=0, dwell=20.
4. Priority:
   - hit on final SHOW cycle (timer==0) → counted as hit, miss_cnt unchanged.
   - hit and timer_end in same cycle → OVER, level/hit count unchanged.
   - timer_end during GAP → OVER, no mole_req.
5. Target select:
   - rand_seg=7 → segment_select=0.
   - rand_seg equal to prev target 6 → segment_select=0.
   - rand_seg=3 with prev 2 → 3.
6. Async reset asserted mid-SHOW, between clock edges → outputs return to reset values immediately. After release, the game stays IDLE until start.
